// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// IF looks up the fetch PC combinationally; ID reports resolved outcomes,
// which train the tables and raise a mispredict/redirect.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int          ADDR_W   = 32,
  parameter int          ENTRIES  = 16,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       lookups_o,
  output logic [31:0]       mispredicts_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, up_hit;
  logic [ADDR_W-1:0] lk_seq, up_seq, correct_pc;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Sequential PCs wrap modulo 2^ADDR_W.
  assign lk_seq     = lookup_pc_i + ADDR_W'(4);
  assign up_seq     = upd_pc_i + ADDR_W'(4);
  assign correct_pc = upd_taken_i ? upd_target_i : up_seq;
  assign redirect_pc_o = correct_pc;

  // Lookup: predict taken only on a hit with a counter in a taken state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pred_taken_o  = 1'b0;
    pred_target_o = lk_seq;
    if (!rst_i && lk_hit && ctr_q[lk_idx][1]) begin
      pred_taken_o  = 1'b1;
      pred_target_o = target_q[lk_idx];
    end
  end

  // Mispredict: direction or next PC differs from what IF assumed.
  always_comb begin
    mispredict_o = 1'b0;
    if (!rst_i && upd_valid_i)
      mispredict_o = (upd_taken_i != upd_pred_taken_i) ||
                     (correct_pc != upd_pred_target_i);
  end

  // Valid bits and direction counters: reset, then train on resolved branches.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all reads see pre-edge values.
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        if (upd_taken_i && ctr_q[up_idx] != 2'b11)
          ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
        else if (!upd_taken_i && ctr_q[up_idx] != 2'b00)
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= 2'b10;
      end
    end
  end

  // Tags and targets: written on taken updates; never read without a valid bit.
  always_ff @(posedge clk_i) begin
    // NOTE: tag/target storage is deliberately not reset; valid_q guards every read.
    if (!rst_i && upd_valid_i && upd_taken_i) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
    end
  end

`ifdef BP_STATS_EN
  // Statistics: lookups every non-reset cycle, mispredicts every flagged cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookups_o     <= '0;
      mispredicts_o <= '0;
    end else begin
      lookups_o <= lookups_o + 32'd1;
      if (mispredict_o)
        mispredicts_o <= mispredicts_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the 5-stage pipelined CPU. It moves branch/jump redirection from the ID stage to IF. IF looks the fetch PC up combinationally and gets a predicted next PC. ID reports the resolved outcome one or more cycles later, and the block then trains its tables and flags mispredictions so the pipeline can flush IF/ID and redirect the PC.

## Interface
Parameters:
- ADDR_W, 32, PC/target width
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken)

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- lookup_pc_i  in  ADDR_W  PC currently being fetched
- pred_taken_o  out  1  predicted taken (combinational)
- pred_target_o  out  ADDR_W  predicted next PC (combinational)
- upd_valid_i  in  1  ID resolved a branch/jump this cycle
- upd_pc_i  in  ADDR_W  PC of resolved instruction
- upd_taken_i  in  1  actual direction
- upd_target_i  in  ADDR_W  actual taken target
- upd_pred_taken_i  in  1  prediction carried with the instruction through IF/ID
- upd_pred_target_i  in  ADDR_W  predicted next PC carried through IF/ID
- mispredict_o  out  1  flush IF/ID and redirect (combinational)
- redirect_pc_o  out  ADDR_W  correct next PC
- lookups_o, mispredicts_o  out  32  statistics (present only with BP_STATS_EN)

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Per entry: valid, tag, target, 2-bit counter.
- Lookup hit = valid[idx] && tag match.
- On a hit: pred_taken_o = ctr[1]. pred_target_o = target when ctr[1] is set, else lookup_pc_i+4.
- On a miss: pred_taken_o=0, pred_target_o=lookup_pc_i+4.
- Correct next PC = upd_taken_i ? upd_target_i : upd_pc_i+4.
- mispredict_o = upd_valid_i && (upd_taken_i != upd_pred_taken_i || correct next PC != upd_pred_target_i).
- redirect_pc_o = correct next PC. It is driven regardless of upd_valid_i.
- Training happens when upd_valid_i=1:
  - Update hits: the counter increments if taken or decrements if not taken, saturating at 3 and 0. If taken, the target is overwritten with upd_target_i.
  - Update misses and taken: the entry is allocated (replacing any alias): valid=1, tag, target=upd_target_i, ctr=2'b10.
  - Update misses and not taken: no change.
- Adder arithmetic is modulo 2^ADDR_W. PC+4 wraps silently.

## Timing
- Lookup outputs and mispredict_o/redirect_pc_o are pure combinational with zero latency.
- Table writes land on the rising edge and are visible to lookups the next cycle.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents (read-before-write).
- Reset: on an rst_i edge, all valid bits clear and all counters load CTR_INIT; stats clear to 0.
  - While rst_i=1: pred_taken_o=0, pred_target_o=lookup_pc_i+4, mispredict_o=0, and updates are ignored.
  - A reset asserted mid-training discards that cycle's update.
- No stall input. The pipeline holds lookup_pc_i stable when the PC is stalled; repeated lookups have no side effect.

## Configuration
- BP_STATS_EN defined:
  - lookups_o increments every non-reset cycle.
  - mispredicts_o increments every cycle mispredict_o=1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- BP_STATS_EN undefined: both counters and their ports are absent. Prediction behaviour is identical.

## Test plan
All scenarios use ENTRIES=16, ADDR_W=32.
- Reset released, lookup 0x100 -> pred_taken_o=0, pred_target_o=0x104.
- Update pc=0x100, taken, target=0x200, pred_taken=0, pred_target=0x104 -> mispredict_o=1, redirect_pc_o=0x200. Next cycle, lookup 0x100 -> taken, 0x200.
- Four more taken updates on 0x100 (counter saturates at 3), then two not-taken -> counter=1. Lookup 0x100 -> pred_taken_o=0, target 0x104. An update with correct prediction (not taken, pred 0x104) -> mispredict_o=0.
- Aliasing: taken update 0x140->0x300 (same index 0 as 0x100) -> lookup 0x140 hits (0x300), lookup 0x100 misses (0x104).
- Same-cycle lookup 0x180 and allocating update 0x180->0x400 -> that cycle pred_taken_o=0; next cycle taken, 0x400.
- Assert rst_i with a valid update present -> no allocation; all lookups miss afterwards. With BP_STATS_EN, preload via 3 mispredicts -> mispredicts_o=3, and reset -> 0.
